// File: rtl/telemetry_pkt_if.sv
// Byte-stream bus for the telemetry framer: control inputs, channel data,
// the framed byte output, status and debug visibility.
//
// Handshake: a byte moves from master to slave on every rising clk edge where
// out_vld & out_rdy are both 1. Once out_vld is raised, out_vld and out_data
// stay constant until that transfer happens; out_rdy may change freely and
// has no combinational dependence on out_vld.
interface telemetry_pkt_if #(
    parameter int NUM_CH = 3,
    parameter int CH_W   = 12
);
    logic                     en;
    logic                     send_req;
    logic [NUM_CH*CH_W-1:0]   ch_data;
    logic [7:0]               out_data;
    logic                     out_vld;
    logic                     out_rdy;
    logic                     busy;
    logic [7:0]               overrun_cnt;
    logic [2:0]               dbg_state;
    logic [31:0]              dbg_period_cnt;

    modport master (
        input  en, send_req, ch_data, out_rdy,
        output out_data, out_vld, busy, overrun_cnt, dbg_state, dbg_period_cnt
    );

    modport slave (
        output en, send_req, ch_data, out_rdy,
        input  out_data, out_vld, busy, overrun_cnt, dbg_state, dbg_period_cnt
    );
endinterface

// File: rtl/telemetry_pkt.sv
// Periodic telemetry framer. Each frame is DELIM1, DELIM2, then NUM_CH
// channels of ceil(CH_W/8) bytes (channel 0 first, MS byte first, top byte
// zero-padded), then an optional checksum byte. Channels are snapshotted at
// the frame start cycle so later ch_data changes never reach the wire.
// Frame starts while a frame is still in flight are dropped and counted in a
// saturating 8-bit overrun counter.
//
// Optional feature macro: TELEM_CHKSUM_EN -- when defined, a CHK state appends
// the two's complement of the 8-bit payload sum (delimiters excluded).
module telemetry_pkt #(
    parameter int         NUM_CH = 3,
    parameter int         CH_W   = 12,
    parameter int         PERIOD = 1048576,
    parameter logic [7:0] DELIM1 = 8'hAA,
    parameter logic [7:0] DELIM2 = 8'h55
) (
    input  logic            clk,
    input  logic            rst,
    telemetry_pkt_if.master bus
);

    localparam int BPC   = (CH_W + 7) / 8;
    localparam int CNT_W = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam int CH_IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BY_IW = (BPC > 1) ? $clog2(BPC) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(PERIOD - 1);
    localparam logic [CH_IW-1:0] CH_LAST  = CH_IW'(NUM_CH - 1);
    localparam logic [BY_IW-1:0] BY_LAST  = BY_IW'(BPC - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_DLM1 = 3'd1;
    localparam logic [2:0] S_DLM2 = 3'd2;
    localparam logic [2:0] S_PAY  = 3'd3;
`ifdef TELEM_CHKSUM_EN
    localparam logic [2:0] S_CHK  = 3'd4;
`endif

    logic [2:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_CH*CH_W-1:0] snap_q, snap_d;
    logic [CH_IW-1:0]       ch_idx_q, ch_idx_d;
    logic [BY_IW-1:0]       by_idx_q, by_idx_d;
    logic [7:0]             ovr_q, ovr_d;
`ifdef TELEM_CHKSUM_EN
    logic [7:0]             sum_q, sum_d;
`endif

    logic              tick;
    logic              start_req;
    logic              busy;
    logic              xfer;
    logic              last_byte;
    logic [CH_W-1:0]   chan_v;
    logic [BPC*8-1:0]  pad_v;
    logic [7:0]        pay_byte;
    logic [7:0]        byte_out;

    // Status decode: a frame is in flight whenever the FSM is out of IDLE.
    always_comb begin
        tick      = bus.en && (cnt_q == CNT_MAX);
        start_req = tick || bus.send_req;
        busy      = (state_q != S_IDLE);
        xfer      = busy && bus.out_rdy;
        last_byte = (ch_idx_q == CH_LAST) && (by_idx_q == BY_LAST);
    end

    // Payload byte select: pick the channel, zero-pad to whole bytes, take MS byte first.
    always_comb begin
        chan_v = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_idx_q == CH_IW'(c)) begin
                chan_v = snap_q[c*CH_W +: CH_W];
            end
        end
        pad_v = '0;
        pad_v[CH_W-1:0] = chan_v;
        pay_byte = '0;
        for (int b = 0; b < BPC; b++) begin
            if (by_idx_q == BY_IW'(b)) begin
                pay_byte = pad_v[(BPC-1-b)*8 +: 8];
            end
        end
    end

    // Output byte mux keyed only on registered state, so it is stable until transfer.
    always_comb begin
        byte_out = 8'h00;
        case (state_q)
            S_DLM1:  byte_out = DELIM1;
            S_DLM2:  byte_out = DELIM2;
            S_PAY:   byte_out = pay_byte;
`ifdef TELEM_CHKSUM_EN
            S_CHK:   byte_out = 8'h00 - sum_q;
`endif
            default: byte_out = 8'h00;
        endcase
    end

    // Period counter and saturating overrun counter next-state.
    always_comb begin
        cnt_d = cnt_q;
        if (bus.en) begin
            cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        end
        ovr_d = ovr_q;
        if (busy && start_req && (ovr_q != 8'hFF)) begin
            ovr_d = ovr_q + 8'd1;
        end
    end

    // Frame FSM: start from IDLE on a request, advance only on accepted bytes.
    always_comb begin
        state_d  = state_q;
        snap_d   = snap_q;
        ch_idx_d = ch_idx_q;
        by_idx_d = by_idx_q;
`ifdef TELEM_CHKSUM_EN
        sum_d    = sum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_req) begin
                    state_d  = S_DLM1;
                    snap_d   = bus.ch_data;
                    ch_idx_d = '0;
                    by_idx_d = '0;
`ifdef TELEM_CHKSUM_EN
                    sum_d    = 8'h00;
`endif
                end
            end
            S_DLM1: if (xfer) state_d = S_DLM2;
            S_DLM2: if (xfer) state_d = S_PAY;
            S_PAY: begin
                if (xfer) begin
`ifdef TELEM_CHKSUM_EN
                    sum_d = sum_q + pay_byte;
`endif
                    if (last_byte) begin
`ifdef TELEM_CHKSUM_EN
                        state_d = S_CHK;
`else
                        state_d = S_IDLE;
`endif
                    end else if (by_idx_q == BY_LAST) begin
                        by_idx_d = '0;
                        ch_idx_d = ch_idx_q + 1'b1;
                    end else begin
                        by_idx_d = by_idx_q + 1'b1;
                    end
                end
            end
`ifdef TELEM_CHKSUM_EN
            S_CHK: if (xfer) state_d = S_IDLE;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous reset; reset aborts any frame at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            snap_q   <= '0;
            ch_idx_q <= '0;
            by_idx_q <= '0;
            ovr_q    <= 8'h00;
`ifdef TELEM_CHKSUM_EN
            sum_q    <= 8'h00;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            snap_q   <= snap_d;
            ch_idx_q <= ch_idx_d;
            by_idx_q <= by_idx_d;
            ovr_q    <= ovr_d;
`ifdef TELEM_CHKSUM_EN
            sum_q    <= sum_d;
`endif
        end
    end

    assign bus.out_data       = byte_out;
    assign bus.out_vld        = busy;
    assign bus.busy           = busy;
    assign bus.overrun_cnt    = ovr_q;
    assign bus.dbg_state      = state_q;
    assign bus.dbg_period_cnt = 32'(cnt_q);

endmodule
